actor_mover: RTL and testbench
==============================

ACTOR_MOVER -- requirements
Module: actor_mover

Interface
REQ-001 SHALL have parameter START_X, default 15: reset tile column (0..31).
REQ-002 SHALL have parameter START_Y, default 24: reset tile row (0..31).
REQ-003 SHALL have parameter START_DIR, default 3: reset heading.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  movement strobe, one-cycle pulse, e.g. per frame.
REQ-007 req_valid  in  1  direction request strobe.
REQ-008 req_dir  in  2  requested heading: 0 up, 1 right, 2 down, 3 left.
REQ-009 map_addr  out  5  row select to the MapData read port.
REQ-010 map_row  in  32  row data returned combinationally, same cycle.
REQ-011 pos_x, pos_y  out  5 each  current tile column and row.
REQ-012 cur_dir  out  2  current heading.
REQ-013 busy  out  1  high while not IDLE.
REQ-014 blocked  out  1  one-cycle pulse: forward move refused by wall.
REQ-015 wrapped  out  1  one-cycle pulse: move crossed a coordinate edge.

Function
REQ-016 SHALL treat tile (x,y) as wall iff map_row[31-x] = 1 with map_addr = y; MSB is column 0.
REQ-017 SHALL compute neighbour coordinates modulo 32: x=0 left->31, x=31 right->0, y=0 up->31, y=31 down->0; up decrements y.
REQ-018 SHALL hold a one-entry pending request; req_valid in any cycle loads req_dir and sets pending; a later request overwrites.
REQ-019 FSM states IDLE, CHK_TURN, CHK_FWD; IDLE drives map_addr = pos_y.
REQ-020 IDLE: tick=1 -> CHK_TURN; tick=0 -> stay.
REQ-021 CHK_TURN: map_addr = neighbour row in pending dir; if pending and tile open: cur_dir <= pending dir, pending cleared; if pending and wall: pending cleared, cur_dir kept; if none pending: no change; always -> CHK_FWD.
REQ-022 CHK_FWD: map_addr = neighbour row in cur_dir (as updated); open: pos <= neighbour, wrapped pulses if an edge crossed; wall: pos held, blocked pulses; always -> IDLE.
REQ-023 Latency: tick sampled at edge N; pos/cur_dir/blocked/wrapped visible after edge N+2; next tick accepted at edge N+3.
REQ-024 tick while busy=1 SHALL be ignored, not queued.
REQ-025 req_valid in the same cycle CHK_TURN consumes pending SHALL win: the new request stays pending.
REQ-026 Reversal (opposite of cur_dir) SHALL be checked like any other turn.
REQ-027 blocked and wrapped SHALL never be high outside the CHK_FWD-completion cycle; never both high.

Reset
REQ-028 reset=1 SHALL force: state IDLE, pos=(START_X,START_Y), cur_dir=START_DIR, pending clear, blocked=0, wrapped=0, busy=0.
REQ-029 reset mid-operation SHALL abort the move; no partial position or heading update survives.
REQ-030 reset SHALL dominate tick and req_valid in the same cycle.

Structure
REQ-031 Shared package actor_pkg SHALL hold direction constants (DIR_UP..DIR_LEFT), FSM state encoding, and MAP_W=32.
REQ-032 Neighbour/wrap arithmetic SHALL be one combinational sub-module actor_step (in: x, y, dir; out: nx, ny, wrap).
REQ-033 Block SHALL use one map read port; a second actor uses the other MapData port.

Verification (bench models map_row)
REQ-034 Production map, reset, tick, no request -> after 3 cycles pos=(14,24), cur_dir=3, blocked=0.
REQ-035 Production map, reset, req_dir=2 then tick -> (15,25) wall: turn dropped, pos=(14,24), cur_dir=3, pending clear.
REQ-036 Production map, reset, req_dir=0 then tick -> pos=(15,23), cur_dir=0.
REQ-037 All-zero map, START=(0,5), dir 3, tick -> pos=(31,5), wrapped=1 for one cycle.
REQ-038 Map with wall at (14,24), no request, tick -> pos=(15,24), blocked=1 one cycle; second tick during busy ignored.
REQ-039 reset asserted in CHK_TURN cycle after accepted req_dir=0 -> pos=(15,24), cur_dir=3, pending clear.

Source files
------------

// File: rtl/actor_pkg.sv
// Shared constants for the tile-map actor: headings, FSM encoding, map geometry.
package actor_pkg;

  localparam int MAP_W   = 32;
  localparam int COORD_W = 5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHK_TURN = 2'd1,
    ST_CHK_FWD  = 2'd2
  } state_e;

endpackage

// File: rtl/actor_step.sv
// Neighbour tile in a given heading on a 32x32 torus; wrap flags an edge crossing.
module actor_step
  import actor_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] EDGE_MAX = '1;

  always_comb begin
    nx   = x;
    ny   = y;
    wrap = 1'b0;
    unique case (dir)
      DIR_UP: begin
        ny   = y - 1'b1;
        wrap = (y == '0);
      end
      DIR_RIGHT: begin
        nx   = x + 1'b1;
        wrap = (x == EDGE_MAX);
      end
      DIR_DOWN: begin
        ny   = y + 1'b1;
        wrap = (y == EDGE_MAX);
      end
      default: begin
        nx   = x - 1'b1;
        wrap = (x == '0);
      end
    endcase
  end

endmodule

// File: rtl/actor_mover.sv
// Grid actor: per tick, tries a pending turn, then a forward step, checking walls
// through a single map read port (one row per cycle).
module actor_mover
  import actor_pkg::*;
#(
  parameter int START_X   = 15,
  parameter int START_Y   = 24,
  parameter int START_DIR = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 req_valid,
  input  logic [1:0]           req_dir,
  output logic [COORD_W-1:0]   map_addr,
  input  logic [MAP_W-1:0]     map_row,
  output logic [COORD_W-1:0]   pos_x,
  output logic [COORD_W-1:0]   pos_y,
  output logic [1:0]           cur_dir,
  output logic                 busy,
  output logic                 blocked,
  output logic                 wrapped
);

  localparam logic [COORD_W-1:0] RST_X   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] RST_Y   = COORD_W'(START_Y);
  localparam logic [1:0]         RST_DIR = 2'(START_DIR);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(MAP_W - 1);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  pos_x_q, pos_x_d;
  logic [COORD_W-1:0]  pos_y_q, pos_y_d;
  logic [1:0]          cur_dir_q, cur_dir_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_dir_q, pend_dir_d;
  logic                blocked_q, blocked_d;
  logic                wrapped_q, wrapped_d;

  logic [1:0]          step_dir;
  logic [COORD_W-1:0]  step_nx, step_ny;
  logic                step_wrap;
  logic [COORD_W-1:0]  wall_col;
  logic                wall;

  // Probe direction is the pending heading during the turn check, else the current one.
  always_comb begin
    step_dir = (state_q == ST_CHK_TURN) ? pend_dir_q : cur_dir_q;
    map_addr = (state_q == ST_IDLE) ? pos_y_q : step_ny;
  end

  actor_step u_step (
    .x    (pos_x_q),
    .y    (pos_y_q),
    .dir  (step_dir),
    .nx   (step_nx),
    .ny   (step_ny),
    .wrap (step_wrap)
  );

  // Column 0 sits in the row's MSB.
  assign wall_col = COL_MAX - step_nx;
  assign wall     = map_row[wall_col];

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    cur_dir_d  = cur_dir_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    blocked_d  = 1'b0;
    wrapped_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_CHK_TURN;
      end
      ST_CHK_TURN: begin
        if (pend_q) begin
          if (!wall) cur_dir_d = pend_dir_q;
          pend_d = 1'b0;
        end
        state_d = ST_CHK_FWD;
      end
      ST_CHK_FWD: begin
        if (wall) begin
          blocked_d = 1'b1;
        end else begin
          pos_x_d   = step_nx;
          pos_y_d   = step_ny;
          wrapped_d = step_wrap;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh request overrides the consume in the same cycle.
    if (req_valid) begin
      pend_d     = 1'b1;
      pend_dir_d = req_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pos_x_q    <= RST_X;
      pos_y_q    <= RST_Y;
      cur_dir_q  <= RST_DIR;
      pend_q     <= 1'b0;
      pend_dir_q <= DIR_UP;
      blocked_q  <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      cur_dir_q  <= cur_dir_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      blocked_q  <= blocked_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign cur_dir = cur_dir_q;
  assign busy    = (state_q != ST_IDLE);
  assign blocked = blocked_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_actor_mover.sv
// Directed bench for actor_mover: a behavioural map feeds map_row from map_addr.
module tb_actor_mover;

  logic        clk = 1'b0;
  logic        reset, tick, req_valid;
  logic [1:0]  req_dir;
  logic [4:0]  map_addr, pos_x, pos_y;
  logic [31:0] map_row;
  logic [1:0]  cur_dir;
  logic        busy, blocked, wrapped;

  logic [4:0]  map_addr2, pos_x2, pos_y2;
  logic [31:0] map_row2;
  logic [1:0]  cur_dir2;
  logic        busy2, blocked2, wrapped2;

  int map_mode;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // mode 0: production map (border columns/rows, wall at (15,25));
  // mode 2: open map with a single wall at (14,24)
  function automatic logic [31:0] map_of(input int mode, input logic [4:0] row);
    logic [31:0] r;
    r = 32'h0;
    if (mode == 0) begin
      if (row == 5'd0 || row == 5'd31) r = 32'hFFFF_FFFF;
      else r = 32'h8000_0001;
      if (row == 5'd25) r = r | 32'h0001_0000;
    end else if (mode == 2) begin
      if (row == 5'd24) r = 32'h0002_0000;
    end
    return r;
  endfunction

  always_comb map_row  = map_of(map_mode, map_addr);
  always_comb map_row2 = 32'h0;

  actor_mover dut (
    .clk(clk), .reset(reset), .tick(tick), .req_valid(req_valid), .req_dir(req_dir),
    .map_addr(map_addr), .map_row(map_row), .pos_x(pos_x), .pos_y(pos_y),
    .cur_dir(cur_dir), .busy(busy), .blocked(blocked), .wrapped(wrapped)
  );

  actor_mover #(.START_X(0), .START_Y(5), .START_DIR(3)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .req_valid(req_valid), .req_dir(req_dir),
    .map_addr(map_addr2), .map_row(map_row2), .pos_x(pos_x2), .pos_y(pos_y2),
    .cur_dir(cur_dir2), .busy(busy2), .blocked(blocked2), .wrapped(wrapped2)
  );

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic request(input logic [1:0] d);
    req_valid = 1'b1; req_dir = d;
    cyc();
    req_valid = 1'b0;
  endtask

  // tick for one cycle, then wait until the move completes (edge N+2)
  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    map_mode = 0;
    do_reset();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd15, 5'd24, 2'd3}) begin
      $display("FAIL reset_pos: got x=%0d y=%0d dir=%0d, expected x=15 y=24 dir=3", pos_x, pos_y, cur_dir);
      errors++;
    end
    checks++;
    if ({busy, blocked, wrapped} !== 3'b000) begin
      $display("FAIL reset_flags: got busy/blk/wrp=%b, expected 000", {busy, blocked, wrapped});
      errors++;
    end
    // reset dominates tick and a request in the same cycle
    reset = 1'b1; tick = 1'b1; req_valid = 1'b1; req_dir = 2'd0;
    cyc();
    reset = 1'b0; tick = 1'b0; req_valid = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_dominates_tick: got busy=%0d, expected 0", busy);
      errors++;
    end
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd14, 5'd24, 2'd3}) begin
      $display("FAIL reset_dominates_req: got x=%0d y=%0d dir=%0d, expected x=14 y=24 dir=3", pos_x, pos_y, cur_dir);
      errors++;
    end
  endtask

  task automatic test_forward();
    map_mode = 0;
    do_reset();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL fwd_busy: got busy=%0d, expected 1", busy);
      errors++;
    end
    cyc(2);
    checks++;
    if ({pos_x, pos_y, cur_dir, blocked, busy} !== {5'd14, 5'd24, 2'd3, 1'b0, 1'b0}) begin
      $display("FAIL fwd_move: got x=%0d y=%0d dir=%0d blk=%0d busy=%0d, expected 14 24 3 0 0",
               pos_x, pos_y, cur_dir, blocked, busy);
      errors++;
    end
  endtask

  task automatic test_turn_blocked();
    map_mode = 0;
    do_reset();
    request(2'd2);
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd14, 5'd24, 2'd3}) begin
      $display("FAIL turn_wall: got x=%0d y=%0d dir=%0d, expected x=14 y=24 dir=3", pos_x, pos_y, cur_dir);
      errors++;
    end
    // pending was dropped: the next tick keeps going left
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd13, 5'd24, 2'd3}) begin
      $display("FAIL turn_wall_pending_clear: got x=%0d y=%0d dir=%0d, expected x=13 y=24 dir=3", pos_x, pos_y, cur_dir);
      errors++;
    end
  endtask

  task automatic test_turn_open();
    map_mode = 0;
    do_reset();
    request(2'd0);
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd15, 5'd23, 2'd0}) begin
      $display("FAIL turn_up: got x=%0d y=%0d dir=%0d, expected x=15 y=23 dir=0", pos_x, pos_y, cur_dir);
      errors++;
    end
    // later request overwrites: down (wall) replaced by up
    do_reset();
    request(2'd2);
    request(2'd0);
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd15, 5'd23, 2'd0}) begin
      $display("FAIL req_overwrite: got x=%0d y=%0d dir=%0d, expected x=15 y=23 dir=0", pos_x, pos_y, cur_dir);
      errors++;
    end
    // reversal from left to right
    do_reset();
    request(2'd1);
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd16, 5'd24, 2'd1}) begin
      $display("FAIL reversal: got x=%0d y=%0d dir=%0d, expected x=16 y=24 dir=1", pos_x, pos_y, cur_dir);
      errors++;
    end
  endtask

  task automatic test_wrap();
    map_mode = 0;
    do_reset();
    tick = 1'b1;
    cyc(2);
    tick = 1'b0;
    checks++;
    if (wrapped2 !== 1'b0) begin
      $display("FAIL wrap_early: got wrapped=%0d, expected 0", wrapped2);
      errors++;
    end
    cyc();
    checks++;
    if ({pos_x2, pos_y2, wrapped2, blocked2} !== {5'd31, 5'd5, 1'b1, 1'b0}) begin
      $display("FAIL wrap_left: got x=%0d y=%0d wrp=%0d blk=%0d, expected 31 5 1 0",
               pos_x2, pos_y2, wrapped2, blocked2);
      errors++;
    end
    cyc();
    checks++;
    if (wrapped2 !== 1'b0) begin
      $display("FAIL wrap_pulse_len: got wrapped=%0d, expected 0", wrapped2);
      errors++;
    end
  endtask

  task automatic test_blocked_busy_tick();
    map_mode = 2;
    do_reset();
    tick = 1'b1;
    cyc(2);
    tick = 1'b0;
    cyc();
    checks++;
    if ({pos_x, pos_y, blocked, wrapped, busy} !== {5'd15, 5'd24, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL fwd_blocked: got x=%0d y=%0d blk=%0d wrp=%0d busy=%0d, expected 15 24 1 0 0",
               pos_x, pos_y, blocked, wrapped, busy);
      errors++;
    end
    cyc();
    checks++;
    if ({blocked, busy} !== 2'b00) begin
      $display("FAIL busy_tick_ignored: got blk=%0d busy=%0d, expected 0 0", blocked, busy);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    map_mode = 0;
    do_reset();
    request(2'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    // new request in the CHK_TURN cycle survives the consume
    req_valid = 1'b1; req_dir = 2'd1;
    cyc();
    req_valid = 1'b0;
    cyc();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd15, 5'd23, 2'd0}) begin
      $display("FAIL b2b_first: got x=%0d y=%0d dir=%0d, expected x=15 y=23 dir=0", pos_x, pos_y, cur_dir);
      errors++;
    end
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd16, 5'd23, 2'd1}) begin
      $display("FAIL b2b_second: got x=%0d y=%0d dir=%0d, expected x=16 y=23 dir=1", pos_x, pos_y, cur_dir);
      errors++;
    end
  endtask

  task automatic test_reset_mid_move();
    map_mode = 0;
    do_reset();
    request(2'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({pos_x, pos_y, cur_dir, busy} !== {5'd15, 5'd24, 2'd3, 1'b0}) begin
      $display("FAIL reset_mid: got x=%0d y=%0d dir=%0d busy=%0d, expected 15 24 3 0", pos_x, pos_y, cur_dir, busy);
      errors++;
    end
    do_tick();
    checks++;
    if ({pos_x, pos_y, cur_dir} !== {5'd14, 5'd24, 2'd3}) begin
      $display("FAIL reset_mid_pending: got x=%0d y=%0d dir=%0d, expected x=14 y=24 dir=3", pos_x, pos_y, cur_dir);
      errors++;
    end
  endtask

  initial begin
    map_mode = 0;
    reset = 1'b1; tick = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
    test_reset();
    test_forward();
    test_turn_blocked();
    test_turn_open();
    test_wrap();
    test_blocked_busy_tick();
    test_back_to_back();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
